// File: rtl/shifter_pkg.sv
// Op codes and helpers shared by the pipelined barrel shifter and its mux levels.
package shifter_pkg;

  localparam logic [2:0] OP_SLL = 3'b000;
  localparam logic [2:0] OP_SRL = 3'b001;
  localparam logic [2:0] OP_SRA = 3'b010;
  localparam logic [2:0] OP_ROL = 3'b011;
  localparam logic [2:0] OP_ROR = 3'b100;

  function automatic logic is_reserved_op(input logic [2:0] op);
    return op > OP_ROR;
  endfunction

endpackage

// File: rtl/barrel_shift_level.sv
// One combinational mux level: shifts or rotates by DIST when en is set.
module barrel_shift_level
  import shifter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  logic [WIDTH-1:0] data,
  input  logic             en,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] res
);

  always_comb begin
    res = data;
    if (en) begin
      case (op)
        OP_SLL:  res = data << DIST;
        OP_SRL:  res = data >> DIST;
        OP_SRA:  res = $signed(data) >>> DIST;
        OP_ROL:  res = {data[WIDTH-DIST-1:0], data[WIDTH-1:WIDTH-DIST]};
        OP_ROR:  res = {data[DIST-1:0], data[WIDTH-1:DIST]};
        // reserved ops pass the operand through untouched
        default: res = data;
      endcase
    end
  end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA/ROL/ROR shifter with valid/ready on both sides and a sideband tag.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int STAGES = 2,
  parameter  int TAG_W  = 4,
  localparam int LOG2W  = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LOG2W-1:0] in_shamt,
  input  logic [2:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  if (WIDTH < 2 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: WIDTH must be a power of two >= 2");
  end
  if (STAGES < 1 || STAGES > LOG2W) begin : g_bad_stages
    $error("pipelined_barrel_shifter: STAGES must be in 1..LOG2W");
  end

  // stage registers
  logic [STAGES-1:0] vld_pipe;
  logic [WIDTH-1:0]  data_q [STAGES];
  logic [LOG2W-1:0]  sh_q   [STAGES];
  logic [2:0]        op_q   [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [STAGES-1:0] err_q;

  // what each stage would capture this cycle
  logic              vld_d  [STAGES];
  logic [WIDTH-1:0]  data_d [STAGES];
  logic [LOG2W-1:0]  sh_d   [STAGES];
  logic [2:0]        op_d   [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];
  logic              err_d  [STAGES];
  logic [STAGES-1:0] load;

  for (genvar s = 0; s < STAGES; s++) begin : g_stg
    if (s == 0) begin : g_head
      assign vld_d[s] = in_valid;
      assign sh_d[s]  = in_shamt;
      assign op_d[s]  = in_op;
      assign tag_d[s] = in_tag;
      assign err_d[s] = is_reserved_op(in_op);
    end else begin : g_body
      assign vld_d[s] = vld_pipe[s-1];
      assign sh_d[s]  = sh_q[s-1];
      assign op_d[s]  = op_q[s-1];
      assign tag_d[s] = tag_q[s-1];
      assign err_d[s] = err_q[s-1];
    end
  end

  // level k lives in stage k*STAGES/LOG2W; levels sharing a stage chain combinationally
  for (genvar k = 0; k < LOG2W; k++) begin : g_lvl
    localparam int S     = (k * STAGES) / LOG2W;
    localparam bit FIRST = (k == 0) || (((k - 1) * STAGES) / LOG2W != S);
    localparam bit LAST  = (k == LOG2W - 1) || (((k + 1) * STAGES) / LOG2W != S);
    logic [WIDTH-1:0] din, dout;

    if (!FIRST) begin : g_chain
      assign din = g_lvl[k-1].dout;
    end else if (S == 0) begin : g_in
      assign din = in_data;
    end else begin : g_reg
      assign din = data_q[S-1];
    end

    barrel_shift_level #(.WIDTH(WIDTH), .DIST(1 << k)) u_level (
      .data (din),
      .en   (sh_d[S][k]),
      .op   (op_d[S]),
      .res  (dout)
    );

    if (LAST) begin : g_out
      assign data_d[S] = dout;
    end
  end

  // a stage moves when it is empty or its successor moves; empty stages soak up bubbles
  always_comb begin
    load = '0;
    load[STAGES-1] = !vld_pipe[STAGES-1] || out_ready;
    for (int s = STAGES - 2; s >= 0; s--)
      load[s] = !vld_pipe[s] || load[s+1];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vld_pipe <= '0;
      err_q    <= '0;
      for (int s = 0; s < STAGES; s++) begin
        data_q[s] <= '0;
        sh_q[s]   <= '0;
        op_q[s]   <= '0;
        tag_q[s]  <= '0;
      end
    end else begin
      for (int s = 0; s < STAGES; s++) begin
        if (load[s]) begin
          vld_pipe[s] <= vld_d[s];
          if (vld_d[s]) begin
            data_q[s] <= data_d[s];
            sh_q[s]   <= sh_d[s];
            op_q[s]   <= op_d[s];
            tag_q[s]  <= tag_d[s];
            err_q[s]  <= err_d[s];
          end
        end
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = vld_pipe[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign out_err   = err_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Drives three shifter configurations (32/2, 8/1, 8/3) against an arithmetic reference scoreboard.
module tb_pipelined_barrel_shifter;
  import shifter_pkg::*;

  localparam int WD [3] = '{32, 8, 8};
  localparam int STG[3] = '{2, 1, 3};

  typedef struct {
    logic [31:0] data;
    logic [3:0]  tag;
    logic        err;
    bit          lat;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ivld[3], ordy[3], irdy[3], ovld[3], oerr[3];
  logic [31:0] idat[3], odat[3];
  logic [4:0]  ish[3];
  logic [2:0]  iop[3];
  logic [3:0]  itag[3], otag[3];
  logic [31:0] o32;
  logic [7:0]  o8a, o8b;

  assign odat[0] = o32;
  assign odat[1] = {24'h0, o8a};
  assign odat[2] = {24'h0, o8b};

  pipelined_barrel_shifter #(.WIDTH(32), .STAGES(2), .TAG_W(4)) u_w32s2 (
    .clock(clk), .reset_n(rst_n), .in_valid(ivld[0]), .in_ready(irdy[0]),
    .in_data(idat[0]), .in_shamt(ish[0]), .in_op(iop[0]), .in_tag(itag[0]),
    .out_valid(ovld[0]), .out_ready(ordy[0]), .out_data(o32), .out_tag(otag[0]),
    .out_err(oerr[0]));

  pipelined_barrel_shifter #(.WIDTH(8), .STAGES(1), .TAG_W(4)) u_w8s1 (
    .clock(clk), .reset_n(rst_n), .in_valid(ivld[1]), .in_ready(irdy[1]),
    .in_data(idat[1][7:0]), .in_shamt(ish[1][2:0]), .in_op(iop[1]), .in_tag(itag[1]),
    .out_valid(ovld[1]), .out_ready(ordy[1]), .out_data(o8a), .out_tag(otag[1]),
    .out_err(oerr[1]));

  pipelined_barrel_shifter #(.WIDTH(8), .STAGES(3), .TAG_W(4)) u_w8s3 (
    .clock(clk), .reset_n(rst_n), .in_valid(ivld[2]), .in_ready(irdy[2]),
    .in_data(idat[2][7:0]), .in_shamt(ish[2][2:0]), .in_op(iop[2]), .in_tag(itag[2]),
    .out_valid(ovld[2]), .out_ready(ordy[2]), .out_data(o8b), .out_tag(otag[2]),
    .out_err(oerr[2]));

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cnt     = 0;
  bit          lat_mode;
  logic [31:0] exp_d[3];
  logic        exp_e[3];
  bit          stall[3];
  bit          accepted[3];
  logic [37:0] held[3];
  exp_t        q[3][$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: shifts on a wide integer, then mask to the configured width.
  function automatic logic [31:0] ref_model(input int w, input logic [31:0] d,
                                            input int s, input logic [2:0] op);
    longint unsigned m, x, r;
    m = (64'd1 << w) - 1;
    x = {32'h0, d} & m;
    case (op)
      3'd0:    r = x << s;
      3'd1:    r = x >> s;
      3'd2:    r = (x >> s) | (((x >> (w - 1)) != 0) ? (m & ~(m >> s)) : 64'd0);
      3'd3:    r = (x << s) | (x >> (w - s));
      3'd4:    r = (x >> s) | (x << (w - s));
      default: r = x;
    endcase
    r = r & m;
    return r[31:0];
  endfunction

  task automatic drive(input int d, input logic [31:0] data, input int s,
                       input logic [2:0] op, input logic [3:0] tag);
    logic [31:0] msk;
    msk     = (WD[d] == 32) ? 32'hFFFF_FFFF : ((32'd1 << WD[d]) - 1);
    ivld[d] = 1'b1;
    idat[d] = data & msk;
    ish[d]  = 5'(s);
    iop[d]  = op;
    itag[d] = tag;
    exp_d[d] = ref_model(WD[d], data & msk, s, op);
    exp_e[d] = (op >= 3'd5);
  endtask

  // Check outputs just before the edge, record acceptances, then advance one cycle.
  task automatic cyc();
    exp_t e;
    #1;
    for (int d = 0; d < 3; d++) begin
      if (stall[d]) chk("stall_hold", {ovld[d], odat[d], otag[d], oerr[d]}, held[d]);
      if (ovld[d] && ordy[d]) begin
        chk("no_spurious", q[d].size() != 0, 1);
        if (q[d].size() != 0) begin
          e = q[d].pop_front();
          chk("out_data", odat[d], e.data);
          chk("out_tag", otag[d], e.tag);
          chk("out_err", oerr[d], e.err);
          if (e.lat) chk("latency", cnt - e.acc, STG[d]);
        end
      end
      stall[d]    = ovld[d] && !ordy[d];
      held[d]     = {ovld[d], odat[d], otag[d], oerr[d]};
      accepted[d] = ivld[d] && irdy[d];
      if (accepted[d]) begin
        e = '{data: exp_d[d], tag: itag[d], err: exp_e[d], lat: lat_mode, acc: cnt};
        q[d].push_back(e);
      end
    end
    @(posedge clk);
    cnt++;
    #1;
  endtask

  task automatic idle(input int n);
    for (int d = 0; d < 3; d++) ivld[d] = 1'b0;
    repeat (n) cyc();
  endtask

  initial begin
    int acc, cycles;
    int accn[3];
    bit took[3];
    for (int d = 0; d < 3; d++) begin
      ivld[d] = 0; ordy[d] = 1; idat[d] = '0; ish[d] = '0; iop[d] = '0; itag[d] = '0;
      stall[d] = 0; accepted[d] = 0; accn[d] = 0; took[d] = 1;
    end
    #2;
    for (int d = 0; d < 3; d++) begin
      chk("rst_out_valid", ovld[d], 0);
      chk("rst_out_data", odat[d], 0);
      chk("rst_out_tag", otag[d], 0);
      chk("rst_out_err", oerr[d], 0);
      chk("rst_in_ready", irdy[d], 1);
    end
    #10 rst_n = 1'b1;

    // directed vectors, back-to-back, latency checked on each result
    lat_mode = 1;
    drive(0, 32'h77F1F54E, 20, OP_SLL, 1); exp_d[0] = 32'h54E00000;
    drive(1, 32'hB4, 3, OP_ROR, 1);        exp_d[1] = 32'h96;
    drive(2, 32'hB4, 3, OP_ROR, 1);        exp_d[2] = 32'h96;
    cyc();
    drive(0, 32'h77F1F54E, 20, OP_SRA, 2); exp_d[0] = 32'h0000077F;
    drive(1, 32'hB4, 2, OP_SRA, 2);        exp_d[1] = 32'hED;
    drive(2, 32'hB4, 2, OP_SRA, 2);        exp_d[2] = 32'hED;
    cyc();
    ivld[1] = 0; ivld[2] = 0;
    drive(0, 32'h77F1F54E, 8, OP_ROR, 3);  exp_d[0] = 32'h4E77F1F5; cyc();
    drive(0, 32'h77F1F54E, 4, OP_ROL, 4);  exp_d[0] = 32'h7F1F54E7; cyc();
    drive(0, 32'h80000000, 31, OP_SRA, 5); exp_d[0] = 32'hFFFFFFFF; cyc();
    drive(0, 32'h80000000, 31, OP_SRL, 6); exp_d[0] = 32'h00000001; cyc();
    drive(0, 32'h00000000, 20, OP_SLL, 7); exp_d[0] = 32'h00000000; cyc();
    for (int op = 0; op < 8; op++) begin
      for (int d = 0; d < 3; d++) begin
        drive(d, $urandom, 0, 3'(op), 4'(op));
        exp_d[d] = idat[d];
        exp_e[d] = (op >= 5);
      end
      cyc();
    end
    ivld[1] = 0; ivld[2] = 0;
    drive(0, 32'h12345678, 5, 3'b110, 9); exp_d[0] = 32'h12345678; exp_e[0] = 1; cyc();
    drive(0, 32'h12345678, 5, OP_SLL, 10); exp_d[0] = 32'h468ACF00; exp_e[0] = 0; cyc();
    idle(6);
    for (int d = 0; d < 3; d++) chk("directed_drained", q[d].size(), 0);

    // backpressure: four tagged ops against a stalled consumer
    lat_mode = 0;
    ordy[0] = 0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      if (i == 0 || accepted[0])
        drive(0, $urandom, $urandom_range(0, 31), 3'($urandom_range(0, 4)), 4'(acc + 1));
      #1;
      chk("bp_in_ready", irdy[0], acc < 2);
      cyc();
      acc += int'(accepted[0]);
    end
    ordy[0] = 1;
    for (int i = 0; i < 10 && acc < 4; i++) begin
      if (accepted[0])
        drive(0, $urandom, $urandom_range(0, 31), 3'($urandom_range(0, 4)), 4'(acc + 1));
      cyc();
      acc += int'(accepted[0]);
    end
    ivld[0] = 0;
    chk("bp_all_accepted", acc, 4);
    idle(5);
    chk("bp_drained", q[0].size(), 0);

    // reset with two ops in flight
    ordy[0] = 0;
    drive(0, $urandom, 3, OP_SLL, 5); cyc();
    drive(0, $urandom, 7, OP_ROR, 6); cyc();
    ivld[0] = 0;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", ovld[0], 0);
    chk("midrst_out_data", o32, 0);
    chk("midrst_in_ready", irdy[0], 1);
    for (int d = 0; d < 3; d++) begin
      q[d].delete();
      stall[d] = 0;
    end
    ordy[0] = 1;
    #1 rst_n = 1'b1;
    idle(5);
    lat_mode = 1;
    drive(0, 32'hF0F0F0F0, 4, OP_ROL, 7); cyc();
    idle(4);
    chk("post_rst_done", q[0].size(), 0);

    // randomised traffic with random consumer stalls
    lat_mode = 0;
    cycles = 0;
    while ((accn[1] < 1000 || accn[2] < 1000) && cycles < 4000) begin
      for (int d = 0; d < 3; d++) begin
        if (took[d]) begin
          if ($urandom_range(0, 3) != 0)
            drive(d, $urandom, $urandom_range(0, WD[d] - 1), 3'($urandom_range(0, 7)),
                  4'($urandom_range(0, 15)));
          else
            ivld[d] = 0;
        end
        ordy[d] = ($urandom_range(0, 3) != 0);
      end
      cyc();
      for (int d = 0; d < 3; d++) begin
        took[d] = !ivld[d] || accepted[d];
        accn[d] += int'(accepted[d]);
      end
      cycles++;
    end
    chk("rand_ops_done", (accn[1] >= 1000) && (accn[2] >= 1000), 1);
    for (int d = 0; d < 3; d++) ordy[d] = 1;
    idle(8);
    for (int d = 0; d < 3; d++) chk("rand_drained", q[d].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
Parametrised, pipelined successor to the ALU's 32-bit combinational SLL/SRA shifter. It adds logical right shift and both rotates, a configurable data width and pipeline depth, and valid/ready handshakes on input and output. It sits between the ALU operand/opcode decode and the writeback mux. An optional sideband tag rides alongside each operation.

Parameters:
WIDTH, 32, data width; must be a power of two, at least 2
STAGES, 2, pipeline register stages (1..LOG2W); LOG2W = $clog2(WIDTH) is derived, not overridable
TAG_W, 4, sideband tag width carried unmodified with each operation

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  asynchronous, active-low reset
in_valid  input  1  an operation is presented
in_ready  output  1  shifter can accept this cycle
in_data  input  WIDTH  operand
in_shamt  input  LOG2W  shift amount
in_op  input  3  operation code (shifter_pkg)
in_tag  input  TAG_W  sideband tag
out_valid  output  1  result is presented
out_ready  input  1  consumer accepts the result this cycle
out_data  output  WIDTH  result
out_tag  output  TAG_W  tag of the result
out_err  output  1  the op code was reserved

Behaviour:
- Reset is asynchronous and active-low. Reset values: all stage valid bits 0; out_valid 0; out_data 0; out_tag 0; out_err 0.
- Reset asserted mid-operation discards every in-flight operation. in_ready is 1 during reset.
- Op codes:
  - 000 SLL: zero fill.
  - 001 SRL: zero fill.
  - 010 SRA: fill with in_data[WIDTH-1].
  - 011 ROL.
  - 100 ROR.
  - 101..111 reserved: out_data = in_data, out_err = 1.
- in_shamt = 0 returns in_data unchanged for every op, with out_err 0 for legal ops.
- Shift by WIDTH-1 is legal for every op. There is no modulo or clamp beyond the LOG2W-bit field.
- Structure: LOG2W mux levels. Level k shifts or rotates by 2^k when shamt[k] = 1, processed LSB first.
- Level k sits in pipeline stage floor(k*STAGES/LOG2W). Each stage ends in a register carrying valid, data, remaining shamt bits, op, tag and err.
- Latency: exactly STAGES cycles from the accepting edge (in_valid and in_ready) to out_valid, when unstalled.
- Throughput: one operation per cycle while out_ready = 1.
- Handshake:
  - Stage i loads when it is empty or when stage i+1 loads (or, for the last stage, when out_ready = 1).
  - in_ready = stage 0 load condition. in_ready is combinational from out_ready through the stall chain; there is no skid buffer.
  - Bubbles collapse: an empty stage accepts even while a downstream stage is stalled.
  - out_valid with out_data, out_tag and out_err hold stable while out_ready = 0.
  - in_valid = 0 never creates a spurious output.
- Simultaneous events:
  - Accept on input and release on output in the same cycle: both occur, and occupancy is unchanged.
  - With the pipeline full and out_ready = 0, in_ready = 0. Input held by the producer is not lost.
- Results leave in acceptance order. Tags are never reordered or altered.
- Elaboration error if WIDTH is not a power of two or STAGES is outside 1..LOG2W.

Decomposition:
- Package shifter_pkg holds the op codes (OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR) as localparam constants, plus the function is_reserved_op.
- Sub-module barrel_shift_level: one combinational mux level.
  - Parameters: WIDTH, DIST.
  - Inputs: data, enable bit, op.
  - Output: data.
  - The top level instantiates LOG2W of these.
- The top level owns the stage registers and handshake logic.

Test Plan:
- WIDTH=32, STAGES=2, out_ready=1:
  - 0x77F1F54E SLL 20 -> 0x54E00000
  - 0x77F1F54E SRA 20 -> 0x0000077F
  - 0x77F1F54E ROR 8 -> 0x4E77F1F5
  - 0x77F1F54E ROL 4 -> 0x7F1F54E7
  - Each out_valid arrives exactly 2 cycles after acceptance, back-to-back.
- Edge amounts:
  - 0x80000000 SRA 31 -> 0xFFFFFFFF
  - 0x80000000 SRL 31 -> 0x00000001
  - 0x00000000 SLL 20 -> 0x00000000
  - shamt 0 with any op -> input unchanged
- Backpressure, STAGES=2: hold out_ready=0 and offer 4 ops with tags 1..4.
  - in_ready drops after 2 accepts.
  - Release out_ready: results emerge with tags 1,2,3,4 in order, none lost or duplicated, outputs stable while stalled.
- Reserved op 110 on 0x12345678 shamt 5 -> out_data 0x12345678, out_err=1; the next legal op -> out_err=0.
- Assert reset_n low with 2 ops in flight:
  - Immediately out_valid=0 and out_data=0.
  - After release, no stale results appear; a new op completes with normal latency.
- Parameter sweep WIDTH=8, STAGES=1 and STAGES=3 (every LOG2W level registered):
  - 0xB4 ROR 3 -> 0x96
  - 0xB4 SRA 2 -> 0xED
  - Latency equals STAGES.
  - Randomised 1000-op scoreboard with random out_ready matches a reference model.
